// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A pixel-clock divider produces a one-clk pixpulse; hcount/vcount advance on it
// and the sync/blank/de flags are registered from the next counter values, so
// they always describe the counters currently on the outputs.
// Optional feature: define VGA_TIMING_LINE_IRQ_EN to add irq_line/line_irq,
// a one-clk pulse when the beam enters horizontal blank on a chosen line.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 11,
    parameter int FW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
`ifdef VGA_TIMING_LINE_IRQ_EN
    input  logic [CW-1:0] irq_line,
    output logic          line_irq,
`endif
    output logic          pixpulse,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          sof,
    output logic          eol,
    output logic [FW-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_DISP   = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_DISP   = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam logic          HS_ON    = (H_SYNC > 0);
    localparam logic          VS_ON    = (V_SYNC > 0);
    localparam logic          HS_ACT   = (HSYNC_POL != 0);
    localparam logic          VS_ACT   = (VSYNC_POL != 0);

    // Parameter sets the counters cannot represent are rejected at elaboration.
    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (longint'(H_TOTAL) > (longint'(1) << CW)) begin : g_chk_h
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_chk_v
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
    end

    // True when c lies in the inclusive window [first, last] and the window exists.
    function automatic logic in_span(input logic [CW-1:0] c,
                                     input logic [CW-1:0] first,
                                     input logic [CW-1:0] last,
                                     input logic          on);
        return on && (c >= first) && (c <= last);
    endfunction

    // Map an in-window flag onto the configured active level.
    function automatic logic sync_level(input logic active, input logic act_lvl);
        return active ? act_lvl : ~act_lvl;
    endfunction

    logic [DW-1:0] div;
    logic [DW-1:0] div_nx;
    logic [CW-1:0] hcount_nx;
    logic [CW-1:0] vcount_nx;
    logic [FW-1:0] frame_nx;
    logic          h_wrap;
    logic          v_wrap;
    logic          sof_r;

    // Pixel strobe and line-end strobe; both suppressed while frozen or in reset.
    always_comb begin
        h_wrap   = (hcount == H_LAST);
        v_wrap   = (vcount == V_LAST);
        pixpulse = en && !rst && (div == DIV_LAST);
        eol      = pixpulse && h_wrap;
        sof      = sof_r && en;
    end

    // Next-state values for divider, raster counters and frame counter.
    always_comb begin
        div_nx    = div;
        hcount_nx = hcount;
        vcount_nx = vcount;
        frame_nx  = frame_count;
        if (en) begin
            div_nx = (div == DIV_LAST) ? '0 : div + 1'b1;
        end
        if (pixpulse) begin
            if (h_wrap) begin
                hcount_nx = '0;
                if (v_wrap) begin
                    vcount_nx = '0;
                    frame_nx  = frame_count + 1'b1;
                end else begin
                    vcount_nx = vcount + 1'b1;
                end
            end else begin
                hcount_nx = hcount + 1'b1;
            end
        end
    end

    // Counter state; holding is implicit because next equals current when frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            frame_count <= '0;
        end else begin
            div         <= div_nx;
            hcount      <= hcount_nx;
            vcount      <= vcount_nx;
            frame_count <= frame_nx;
        end
    end

    // Flags decode the next counters so they change on the same edge as the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hblank <= 1'b0;
            vblank <= 1'b0;
            de     <= 1'b1;
            hsync  <= ~HS_ACT;
            vsync  <= ~VS_ACT;
            sof_r  <= 1'b0;
        end else begin
            hblank <= (hcount_nx >= H_DISP);
            vblank <= (vcount_nx >= V_DISP);
            de     <= (hcount_nx < H_DISP) && (vcount_nx < V_DISP);
            hsync  <= sync_level(in_span(hcount_nx, HS_FIRST, HS_LAST, HS_ON), HS_ACT);
            vsync  <= sync_level(in_span(vcount_nx, VS_FIRST, VS_LAST, VS_ON), VS_ACT);
            sof_r  <= pixpulse && h_wrap && v_wrap;
        end
    end

`ifdef VGA_TIMING_LINE_IRQ_EN
    // Pulse for one clk after the edge where the beam enters blank on irq_line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_irq <= 1'b0;
        end else begin
            line_irq <= pixpulse && (hcount_nx == H_DISP) && (vcount_nx == irq_line);
        end
    end
`endif

endmodule
